lcd_page_sched: RTL
===================

// Module: lcd_page_sched
// PURPOSE
//  Schedules the 16x2 character LCD between NPAGE debug pages (instr/regs/stage/clk count, memory, ...).
//  Selects one 256-bit page string, by button step or auto-rotation.
//  Latches a stable copy of that string for the LCD driver.
//  Issues rate-limited driver restarts so the driver is not reset on every cycle the source data toggles.
//  Sits between the per-page string formatters and the LCD driver's reset/strdata inputs.
// PARAMETERS
//  NPAGE     4            number of pages, >=2
//  RST_CYC   16           cycles drv_reset is held high per restart, >=1
//  HOLD_CYC  25_000_000   minimum cycles from end of a restart pulse to the next restart, >=1
//  ROT_CYC   100_000_000  auto-rotate period in cycles, >=2
// PORTS
//  clk        in   1           system clock; all logic on posedge
//  rst        in   1           synchronous, active-low reset
//  page_data  in   NPAGE*256   page p occupies bits [256*p+255 : 256*p]
//  btn_next   in   1           one-cycle pulse (already debounced): advance page
//  auto_en    in   1           1 = advance page every ROT_CYC cycles
//  strdata    out  256         latched string to LCD driver
//  drv_reset  out  1           active-high restart to LCD driver
//  page_idx   out  clog2(NPAGE)  currently selected page
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - page_idx=0; strdata = 32 x 8'h20 (spaces); drv_reset=1; rotate counter=0; dirty=0.
//   - FSM enters RESTART with its counter cleared, so a first refresh of page 0 always follows reset.
//  Page select (register, every cycle):
//   - Advance when btn_next=1, or when auto_en=1 and the rotate counter hits ROT_CYC-1.
//   - Both in the same cycle advance by exactly one.
//   - Wrap from NPAGE-1 to 0.
//   - Any advance, and auto_en=0, clears the rotate counter.
//   - An advance sets dirty=1.
//  Change detect:
//   - snap holds a copy of the selected page taken at the last restart.
//   - dirty is set when the selected page (page_data slice at page_idx) != snap.
//   - Compare is registered: 1 cycle detect latency.
//  FSM states IDLE, RESTART, HOLD:
//   - IDLE: drv_reset=0. If dirty: load snap and strdata from the selected page, clear dirty, go to RESTART.
//   - RESTART: drv_reset=1 for exactly RST_CYC cycles; strdata stable. Then go to HOLD.
//   - HOLD: drv_reset=0 for HOLD_CYC cycles. Changes occurring here only set dirty. At end, go to IDLE.
//     IDLE sees dirty on the next cycle, so a pending change restarts 1 cycle after HOLD ends.
//   - Dirty set and cleared in the same cycle: set wins.
//   - A change in RESTART/HOLD is never lost; at most one restart is pending, whatever the number of changes.
//  Latency:
//   - From btn_next (in IDLE) to drv_reset rising: 2 cycles (select reg, then IDLE->RESTART).
//   - From a data change (in IDLE) to drv_reset rising: 2 cycles (compare reg, then IDLE->RESTART).
//  Invariants:
//   - strdata changes only on the IDLE->RESTART transition.
//   - drv_reset never drops for under HOLD_CYC cycles between restarts, except via rst.
//  rst asserted mid-RESTART/HOLD aborts immediately to the reset state above.
//  Counters are sized clog2(max parameter + 1); no overflow is possible.
// TESTING  (NPAGE=4, RST_CYC=4, HOLD_CYC=20, ROT_CYC=100, distinct constant pages)
//  1. Release rst, auto_en=0 -> drv_reset high 4 cycles from release, strdata=page0, page_idx=0; then quiet.
//  2. btn_next pulse in IDLE -> page_idx=1; drv_reset rises 2 cycles later for 4 cycles; strdata=page1.
//  3. Toggle page1 bits 5 times inside HOLD -> exactly one restart, 1 cycle after HOLD ends, with the final value.
//  4. auto_en=1 for 400 cycles -> page_idx 1,2,3,0 every 100 cycles; btn_next on the tick cycle -> single step.
//  5. Change data on a non-selected page -> no restart; drv_reset stays 0.
//  6. rst low during RESTART -> next cycle page_idx=0, strdata=spaces, full 4-cycle restart after release.

Source files
------------

// File: rtl/lcd_page_sched.sv
// LCD page scheduler: picks one debug page string, latches it for the
// LCD driver and issues rate-limited driver restarts when the page changes.
module lcd_page_sched #(
  parameter int NPAGE    = 4,
  parameter int RST_CYC  = 16,
  parameter int HOLD_CYC = 25_000_000,
  parameter int ROT_CYC  = 100_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPAGE*256-1:0]       page_data,
  input  logic                       btn_next,
  input  logic                       auto_en,
  output logic [255:0]               strdata,
  output logic                       drv_reset,
  output logic [$clog2(NPAGE)-1:0]   page_idx
);

  localparam int PW   = $clog2(NPAGE);
  localparam int RW   = $clog2(ROT_CYC + 1);
  localparam int MAXC = (RST_CYC > HOLD_CYC) ? RST_CYC : HOLD_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [PW-1:0] PG_LAST   = PW'(NPAGE - 1);
  localparam logic [RW-1:0] ROT_LAST  = RW'(ROT_CYC - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [255:0]  SPACES    = {32{8'h20}};

  typedef enum logic [1:0] {
    IDLE,
    RESTART,
    HOLD
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_rot;
  logic [PW-1:0]   r_page_idx;
  logic [255:0]    r_snap;
  logic [255:0]    r_strdata;
  logic            r_drv_reset;
  logic            r_dirty;
  logic            r_init;

  logic [255:0]    w_sel;
  logic            w_tick;
  logic            w_adv;
  logic            w_load;
  logic            w_diff;

  assign w_sel  = page_data[{r_page_idx, 8'd0} +: 256];
  assign w_tick = auto_en && (r_rot == ROT_LAST);
  assign w_adv  = btn_next || w_tick;
  // First cycle after reset latches page 0 so the post-reset pulse shows it
  assign w_load = r_init || ((r_state == IDLE) && r_dirty);
  // Snap is being replaced this cycle, so a stale compare must not re-arm
  assign w_diff = (w_sel != r_snap) && !w_load;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_page_idx <= '0;
      r_rot      <= '0;
    end else begin
      if (w_adv) begin
        r_page_idx <= (r_page_idx == PG_LAST) ? '0 : r_page_idx + PW'(1);
      end
      if (w_adv || !auto_en) begin
        r_rot <= '0;
      end else begin
        r_rot <= r_rot + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RESTART;
      r_cnt       <= '0;
      r_drv_reset <= 1'b1;
      r_strdata   <= SPACES;
      r_snap      <= SPACES;
      r_dirty     <= 1'b0;
      r_init      <= 1'b1;
    end else begin
      r_dirty <= (r_dirty && !w_load) || w_adv || w_diff;
      r_init  <= 1'b0;
      if (w_load) begin
        r_snap    <= w_sel;
        r_strdata <= w_sel;
      end
      unique case (r_state)
        IDLE: begin
          if (r_dirty) begin
            r_state     <= RESTART;
            r_cnt       <= '0;
            r_drv_reset <= 1'b1;
          end
        end
        RESTART: begin
          if (r_cnt == RST_LAST) begin
            r_state     <= HOLD;
            r_cnt       <= '0;
            r_drv_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_drv_reset <= 1'b0;
        end
      endcase
    end
  end

  assign strdata   = r_strdata;
  assign drv_reset = r_drv_reset;
  assign page_idx  = r_page_idx;

endmodule
